pyrm_fetch_block: RTL and testbench
===================================

// Module: pyrm_fetch_block
// PURPOSE
//  Fetch stage directly upstream of decode. Generates sequential PCs and issues
//  instruction-memory requests. Buffers in-order responses as {inst, pc} in an
//  output FIFO that feeds decode's inst/pc valid/retry inputs.
//  Accepts PC redirects from execute/branch and discards wrong-path responses.
//  Handshake: transfer when valid && !retry.
// PARAMETERS
//  RESET_PC    64'h0  PC after reset (bits [1:0] must be 0)
//  FIFO_DEPTH  2      output FIFO entries; also max in-flight credits (>=1)
// PORTS
//  clk                   in   1   clock
//  reset_pyri            in   1   synchronous, active-low reset
//  imem_addr_pyro        out  64  fetch address
//  imem_addr_valid_pyro  out  1   request valid
//  imem_addr_retry_pyri  in   1   memory not accepting the request
//  imem_data_pyri        in   32  instruction word (in-order response)
//  imem_data_valid_pyri  in   1   response valid
//  imem_data_retry_pyro  out  1   tied 0; space is reserved by credits
//  redirect_pc_pyri      in   64  new fetch target
//  redirect_valid_pyri   in   1   redirect request
//  redirect_retry_pyro   out  1   tied 0; redirect is always taken
//  inst_pyro             out  32  instruction at FIFO head (0 when empty)
//  inst_valid_pyro       out  1   FIFO non-empty
//  inst_retry_pyri       in   1   decode stall
//  pc_pyro               out  64  PC of the head instruction (0 when empty)
//  pc_valid_pyro         out  1   equal to inst_valid_pyro
//  pc_retry_pyri         in   1   decode stall
// BEHAVIOUR
//  State registers:
//   - fetch_pc: next request address.
//   - resp_pc: PC of the next kept response.
//   - outstanding: 0..FIFO_DEPTH, includes requests to be dropped.
//   - drop_cnt: wrong-path responses still to discard.
//   - fifo and count.
//  Reset (reset_pyri==0 at posedge):
//   - fetch_pc = resp_pc = RESET_PC.
//   - outstanding, drop_cnt and count = 0.
//   - All valids 0; imem_addr_pyro = RESET_PC.
//  Request:
//   - imem_addr_pyro = fetch_pc.
//   - valid = !redirect_valid_pyri && (outstanding + count < FIFO_DEPTH).
//   - On accept: fetch_pc += 4 (mod 2^64) and outstanding++.
//   - Max issue rate is 1 request/cycle. First request is possible in the
//     first cycle after reset deasserts.
//  Response:
//   - imem_data_valid_pyri always decrements outstanding.
//   - If drop_cnt != 0 (or a redirect happens this cycle): the response is
//     discarded.
//   - If drop_cnt != 0 and no redirect this cycle: drop_cnt-- as well.
//   - Otherwise push {imem_data_pyri, resp_pc} and resp_pc += 4.
//   - A response with outstanding == 0, or a push into a full FIFO, is a
//     protocol error: ignore it and fire an assertion.
//  Output: pop when count != 0 && !inst_retry_pyri && !pc_retry_pyri.
//   - Push and pop in the same cycle keep count unchanged.
//   - A pushed entry appears on the outputs the next cycle (min 1-cycle
//     response-to-decode latency).
//  Redirect (redirect_valid_pyri=1): wins over every other event that cycle.
//   - fetch_pc = resp_pc = {redirect_pc_pyri[63:2], 2'b00}.
//   - The FIFO is flushed (count = 0); the same-cycle pop and push are discarded.
//   - No request is issued that cycle.
//   - drop_cnt = outstanding - (imem_data_valid_pyri ? 1 : 0).
//   - Back-to-back redirects: the last one wins; drop_cnt recomputes each time.
//  Reset mid-operation: all state is cleared. Responses for pre-reset requests
//   must not arrive (the memory is reset together with fetch).
// TESTING
//  T1:
//   - Stimulus: reset, RESET_PC=0x1000, memory responds 1 cycle after accept,
//     no retry.
//   - Response: inst/pc out at 0x1000, 0x1004, 0x1008, ... each with the
//     correct word.
//  T2:
//   - Stimulus: decode holds inst_retry_pyri=1 for 10 cycles with FIFO_DEPTH=2.
//   - Response: at most 2 requests accepted; outputs hold 0x1000 stable; no
//     loss after release.
//  T3:
//   - Stimulus: with 2 requests outstanding, redirect to 0x2002.
//   - Response: the next 2 responses are dropped; the next output pc is 0x2000;
//     the FIFO is empty the cycle after redirect.
//  T4:
//   - Stimulus: redirect in the same cycle as a response and a pop.
//   - Response: the response is dropped, the pop is not counted, and
//     drop_cnt = outstanding - 1.
//  T5:
//   - Stimulus: fetch_pc = 0xFFFF_FFFF_FFFF_FFFC.
//   - Response: the next request address is 0x0.
//  T6:
//   - Stimulus: assert reset_pyri=0 mid-stream for 1 cycle.
//   - Response: all valids are 0 the next cycle; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/pyrm_fetch_block.sv
// Fetch stage: sequential PC generation, credit-limited imem requests, in-order
// response buffering for decode, redirect with wrong-path response discard.
// Latency: response reaches decode 1 cycle after arrival; up to 1 request/cycle.
// Backpressure: outstanding + buffered never exceeds FIFO_DEPTH, so responses never stall.
module pyrm_fetch_block #(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset_pyri,
  output logic [63:0] imem_addr_pyro,
  output logic        imem_addr_valid_pyro,
  input  logic        imem_addr_retry_pyri,
  input  logic [31:0] imem_data_pyri,
  input  logic        imem_data_valid_pyri,
  output logic        imem_data_retry_pyro,
  input  logic [63:0] redirect_pc_pyri,
  input  logic        redirect_valid_pyri,
  output logic        redirect_retry_pyro,
  output logic [31:0] inst_pyro,
  output logic        inst_valid_pyro,
  input  logic        inst_retry_pyri,
  output logic [63:0] pc_pyro,
  output logic        pc_valid_pyro,
  input  logic        pc_retry_pyri
);

  // Counters span 0..FIFO_DEPTH; pointers index the FIFO storage.
  localparam int unsigned    CW       = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned    PW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW-1:0]  DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [CW:0]    DEPTH_W  = (CW + 1)'(FIFO_DEPTH);
  localparam logic [PW-1:0]  LAST_IDX = PW'(FIFO_DEPTH - 1);

  logic [63:0]   r_fetch_pc;
  logic [63:0]   r_resp_pc;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_drop_cnt;
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [31:0]   r_inst_mem [FIFO_DEPTH];
  logic [63:0]   r_pc_mem   [FIFO_DEPTH];

  logic          w_redirect;
  logic [63:0]   w_redirect_pc;
  logic          w_req_vld;
  logic          w_req_acc;
  logic          w_resp_ok;
  logic          w_has_data;
  logic          w_full;
  logic          w_pop;
  logic          w_drop;
  logic          w_push;
  logic [CW-1:0] w_out_after_resp;
  logic          w_unused;

  // The low address bits of a redirect target are ignored (word-aligned fetch).
  assign w_unused      = &{1'b0, redirect_pc_pyri[1:0]};
  assign w_redirect    = redirect_valid_pyri;
  assign w_redirect_pc = {redirect_pc_pyri[63:2], 2'b00};

  // A request needs a free credit: every in-flight or buffered word owns a FIFO slot.
  assign w_req_vld = reset_pyri && !w_redirect &&
                     (({1'b0, r_outstanding} + {1'b0, r_count}) < DEPTH_W);
  assign w_req_acc = w_req_vld && !imem_addr_retry_pyri;

  // Responses without a matching outstanding request are ignored.
  assign w_resp_ok        = imem_data_valid_pyri && (r_outstanding != '0);
  assign w_out_after_resp = r_outstanding - CW'(w_resp_ok);

  assign w_has_data = (r_count != '0);
  assign w_full     = (r_count == DEPTH_C);
  assign w_pop      = w_has_data && !inst_retry_pyri && !pc_retry_pyri;
  assign w_drop     = w_resp_ok && (r_drop_cnt != '0);
  assign w_push     = w_resp_ok && (r_drop_cnt == '0) && !w_full && !w_redirect;

  assign imem_addr_pyro       = r_fetch_pc;
  assign imem_addr_valid_pyro = w_req_vld;
  assign imem_data_retry_pyro = 1'b0;
  assign redirect_retry_pyro  = 1'b0;
  assign inst_valid_pyro      = w_has_data;
  assign pc_valid_pyro        = w_has_data;
  assign inst_pyro            = w_has_data ? r_inst_mem[r_rd_ptr] : 32'h0;
  assign pc_pyro              = w_has_data ? r_pc_mem[r_rd_ptr]   : 64'h0;

  // Fetch/response PCs, credit count and wrong-path drop counter; redirect overrides all.
  always_ff @(posedge clk) begin
    if (!reset_pyri) begin
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else if (w_redirect) begin
      r_fetch_pc    <= w_redirect_pc;
      r_resp_pc     <= w_redirect_pc;
      r_outstanding <= w_out_after_resp;
      r_drop_cnt    <= w_out_after_resp;
    end else begin
      if (w_req_acc) r_fetch_pc <= r_fetch_pc + 64'd4;
      if (w_push)    r_resp_pc  <= r_resp_pc + 64'd4;
      r_outstanding <= r_outstanding + CW'(w_req_acc) - CW'(w_resp_ok);
      if (w_drop)    r_drop_cnt <= r_drop_cnt - CW'(1);
    end
  end

  // FIFO occupancy and pointers; a redirect flushes the buffered wrong-path words.
  always_ff @(posedge clk) begin
    if (!reset_pyri || w_redirect) begin
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= (r_wr_ptr == LAST_IDX) ? '0 : r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == LAST_IDX) ? '0 : r_rd_ptr + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // FIFO storage: {inst, pc} pairs written at the tail.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_inst_mem[r_wr_ptr] <= imem_data_pyri;
      r_pc_mem[r_wr_ptr]   <= r_resp_pc;
    end
  end

  // Memory protocol: responses need a credit, and kept responses need FIFO space.
  a_resp_has_credit : assert property (@(posedge clk) disable iff (!reset_pyri)
    imem_data_valid_pyri |-> (r_outstanding != '0));
  a_push_has_space : assert property (@(posedge clk) disable iff (!reset_pyri)
    (w_resp_ok && (r_drop_cnt == '0) && !w_redirect) |-> !w_full);

endmodule

// File: tb/tb_pyrm_fetch_block.sv
// Bench for pyrm_fetch_block: randomized and directed stimulus against an
// epoch-tagged model of the fetch stream (correct-path words form a sequential
// PC stream from the latest redirect target; older-epoch responses vanish).
module tb_pyrm_fetch_block;
  localparam logic [63:0] RST_PC = 64'h1000;
  localparam int          DEPTH  = 2;

  logic        clk = 1'b0;
  logic        reset_pyri = 1'b0;
  logic [63:0] imem_addr_pyro;
  logic        imem_addr_valid_pyro;
  logic        imem_addr_retry_pyri = 1'b0;
  logic [31:0] imem_data_pyri = 32'h0;
  logic        imem_data_valid_pyri = 1'b0;
  logic        imem_data_retry_pyro;
  logic [63:0] redirect_pc_pyri = 64'h0;
  logic        redirect_valid_pyri = 1'b0;
  logic        redirect_retry_pyro;
  logic [31:0] inst_pyro;
  logic        inst_valid_pyro;
  logic        inst_retry_pyri = 1'b0;
  logic [63:0] pc_pyro;
  logic        pc_valid_pyro;
  logic        pc_retry_pyri = 1'b0;

  pyrm_fetch_block #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_pyri(reset_pyri),
    .imem_addr_pyro(imem_addr_pyro), .imem_addr_valid_pyro(imem_addr_valid_pyro),
    .imem_addr_retry_pyri(imem_addr_retry_pyri),
    .imem_data_pyri(imem_data_pyri), .imem_data_valid_pyri(imem_data_valid_pyri),
    .imem_data_retry_pyro(imem_data_retry_pyro),
    .redirect_pc_pyri(redirect_pc_pyri), .redirect_valid_pyri(redirect_valid_pyri),
    .redirect_retry_pyro(redirect_retry_pyro),
    .inst_pyro(inst_pyro), .inst_valid_pyro(inst_valid_pyro), .inst_retry_pyri(inst_retry_pyri),
    .pc_pyro(pc_pyro), .pc_valid_pyro(pc_valid_pyro), .pc_retry_pyri(pc_retry_pyri)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    int          ready;
    int          epoch;
  } req_t;

  req_t        q[$];
  int          occ, epoch, cyc, n_checks, n_errors, n_acc, n_pop, lat_max;
  bit          resp_en;
  logic [63:0] exp_req_pc, exp_out_pc, last_acc, last_pop_pc;

  function automatic logic [31:0] word_of(input logic [63:0] a);
    return a[31:0] ^ {a[47:32], a[63:48]} ^ (a[31:0] << 7) ^ 32'hC0DE_0000;
  endfunction

  // One clock cycle: drive memory response, check outputs at negedge, advance model.
  task automatic tick();
    req_t h, r;
    bit   resp, kept, pop, acc, exp_avld, exp_ivld;
    resp = 1'b0;
    kept = 1'b0;
    if (reset_pyri && resp_en && q.size() > 0) resp = (q[0].ready <= cyc);
    imem_data_valid_pyri = resp;
    if (resp) imem_data_pyri = word_of(q[0].addr);
    else      imem_data_pyri = $urandom();
    @(negedge clk);
    exp_avld = reset_pyri && !redirect_valid_pyri && ((q.size() + occ) < DEPTH);
    exp_ivld = (occ != 0);
    n_checks++;
    if (imem_addr_valid_pyro !== exp_avld) begin
      n_errors++;
      $display("FAIL req_valid cyc=%0d got=%b exp=%b", cyc, imem_addr_valid_pyro, exp_avld);
    end
    if (reset_pyri && !redirect_valid_pyri) begin
      n_checks++;
      if (imem_addr_pyro !== exp_req_pc) begin
        n_errors++;
        $display("FAIL req_addr cyc=%0d got=%h exp=%h", cyc, imem_addr_pyro, exp_req_pc);
      end
    end
    n_checks++;
    if (inst_valid_pyro !== exp_ivld || pc_valid_pyro !== exp_ivld) begin
      n_errors++;
      $display("FAIL out_valid cyc=%0d got=%b/%b exp=%b", cyc, inst_valid_pyro, pc_valid_pyro, exp_ivld);
    end
    n_checks++;
    if (exp_ivld) begin
      if (pc_pyro !== exp_out_pc || inst_pyro !== word_of(exp_out_pc)) begin
        n_errors++;
        $display("FAIL out_data cyc=%0d got=%h/%h exp=%h/%h", cyc, pc_pyro, inst_pyro,
                 exp_out_pc, word_of(exp_out_pc));
      end
    end else if (pc_pyro !== 64'h0 || inst_pyro !== 32'h0) begin
      n_errors++;
      $display("FAIL out_zero cyc=%0d got=%h/%h exp=0/0", cyc, pc_pyro, inst_pyro);
    end
    n_checks++;
    if (imem_data_retry_pyro !== 1'b0 || redirect_retry_pyro !== 1'b0) begin
      n_errors++;
      $display("FAIL tied_retry cyc=%0d got=%b/%b exp=0/0", cyc, imem_data_retry_pyro, redirect_retry_pyro);
    end
    pop = exp_ivld && !inst_retry_pyri && !pc_retry_pyri;
    acc = exp_avld && !imem_addr_retry_pyri;
    if (!reset_pyri) begin
      q.delete();
      occ = 0;
      epoch++;
      exp_req_pc = RST_PC;
      exp_out_pc = RST_PC;
    end else begin
      if (resp) begin
        h = q.pop_front();
        kept = (h.epoch == epoch) && !redirect_valid_pyri;
      end
      if (redirect_valid_pyri) begin
        occ = 0;
        epoch++;
        exp_req_pc = {redirect_pc_pyri[63:2], 2'b00};
        exp_out_pc = exp_req_pc;
      end else begin
        if (pop) begin
          occ--;
          n_pop++;
          last_pop_pc = exp_out_pc;
          exp_out_pc += 64'd4;
        end
        if (kept) occ++;
        if (acc) begin
          r.addr  = exp_req_pc;
          r.ready = cyc + ((lat_max > 1) ? $urandom_range(lat_max, 1) : 1);
          r.epoch = epoch;
          q.push_back(r);
          last_acc = exp_req_pc;
          n_acc++;
          exp_req_pc += 64'd4;
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_idle();
    reset_pyri = 1'b1;
    imem_addr_retry_pyri = 1'b0;
    redirect_valid_pyri = 1'b0;
    redirect_pc_pyri = 64'h0;
    inst_retry_pyri = 1'b0;
    pc_retry_pyri = 1'b0;
    resp_en = 1'b1;
    lat_max = 1;
  endtask

  task automatic do_reset();
    set_idle();
    reset_pyri = 1'b0;
    tick();
    reset_pyri = 1'b1;
    #1;
    n_acc = 0;
    n_pop = 0;
  endtask

  task automatic wait_pops(input int target, input int budget, output bit got);
    int n;
    n = 0;
    while (n_pop < target && n < budget) begin
      tick();
      n++;
    end
    got = (n_pop >= target);
  endtask

  task automatic test_reset();
    set_idle();
    reset_pyri = 1'b0;
    tick();
    tick();
    reset_pyri = 1'b1;
    #1;
    n_checks++;
    if (inst_valid_pyro !== 1'b0 || pc_valid_pyro !== 1'b0 || pc_pyro !== 64'h0 || inst_pyro !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_outputs got=%b/%b/%h/%h exp=0/0/0/0", inst_valid_pyro, pc_valid_pyro, pc_pyro, inst_pyro);
    end
    n_checks++;
    if (imem_addr_pyro !== RST_PC || imem_addr_valid_pyro !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_first_req got=%h/%b exp=%h/1", imem_addr_pyro, imem_addr_valid_pyro, RST_PC);
    end
  endtask

  task automatic test_stream();
    do_reset();
    repeat (24) tick();
    n_checks++;
    if (n_pop < 12 || last_pop_pc !== RST_PC + 64'(4 * (n_pop - 1))) begin
      n_errors++;
      $display("FAIL stream pops=%0d last_pc=%h exp>=12 last=%h", n_pop, last_pop_pc, RST_PC + 64'(4 * (n_pop - 1)));
    end
  endtask

  task automatic test_stall();
    bit got;
    do_reset();
    inst_retry_pyri = 1'b1;
    repeat (10) tick();
    n_checks++;
    if (n_acc != DEPTH) begin
      n_errors++;
      $display("FAIL stall_accepts got=%0d exp=%0d", n_acc, DEPTH);
    end
    n_checks++;
    if (inst_valid_pyro !== 1'b1 || pc_pyro !== RST_PC) begin
      n_errors++;
      $display("FAIL stall_hold got=%b/%h exp=1/%h", inst_valid_pyro, pc_pyro, RST_PC);
    end
    inst_retry_pyri = 1'b0;
    wait_pops(6, 30, got);
    n_checks++;
    if (!got || last_pop_pc !== RST_PC + 64'(4 * (n_pop - 1))) begin
      n_errors++;
      $display("FAIL stall_release pops=%0d last=%h exp>=6", n_pop, last_pop_pc);
    end
  endtask

  task automatic test_redirect();
    bit got;
    do_reset();
    resp_en = 1'b0;
    repeat (4) tick();
    n_checks++;
    if (imem_addr_valid_pyro !== 1'b0 || n_acc != 2) begin
      n_errors++;
      $display("FAIL redir_setup got=%b/%0d exp=0/2", imem_addr_valid_pyro, n_acc);
    end
    redirect_valid_pyri = 1'b1;
    redirect_pc_pyri = 64'h2002;
    tick();
    redirect_valid_pyri = 1'b0;
    #1;
    n_checks++;
    if (inst_valid_pyro !== 1'b0 || imem_addr_pyro !== 64'h2000) begin
      n_errors++;
      $display("FAIL redir_after got=%b/%h exp=0/2000", inst_valid_pyro, imem_addr_pyro);
    end
    resp_en = 1'b1;
    wait_pops(1, 20, got);
    n_checks++;
    if (!got || last_pop_pc !== 64'h2000) begin
      n_errors++;
      $display("FAIL redir_first_pc got=%b/%h exp=1/2000", got, last_pop_pc);
    end
  endtask

  task automatic test_same_cycle();
    bit got;
    // Case A: one buffered + one outstanding, redirect with response and pop.
    do_reset();
    resp_en = 1'b0;
    inst_retry_pyri = 1'b1;
    repeat (3) tick();
    resp_en = 1'b1;
    tick();
    n_checks++;
    if (inst_valid_pyro !== 1'b1 || pc_pyro !== RST_PC) begin
      n_errors++;
      $display("FAIL same_setup got=%b/%h exp=1/%h", inst_valid_pyro, pc_pyro, RST_PC);
    end
    inst_retry_pyri = 1'b0;
    redirect_valid_pyri = 1'b1;
    redirect_pc_pyri = 64'h3000;
    n_pop = 0;
    tick();
    redirect_valid_pyri = 1'b0;
    #1;
    n_checks++;
    if (inst_valid_pyro !== 1'b0 || n_pop != 0) begin
      n_errors++;
      $display("FAIL same_flush got=%b pops=%0d exp=0/0", inst_valid_pyro, n_pop);
    end
    wait_pops(1, 20, got);
    n_checks++;
    if (!got || last_pop_pc !== 64'h3000) begin
      n_errors++;
      $display("FAIL same_first_pc got=%b/%h exp=1/3000", got, last_pop_pc);
    end
    // Case B: two outstanding, redirect with a response: one more drop pending.
    do_reset();
    resp_en = 1'b0;
    repeat (3) tick();
    resp_en = 1'b1;
    redirect_valid_pyri = 1'b1;
    redirect_pc_pyri = 64'h4000;
    tick();
    redirect_valid_pyri = 1'b0;
    wait_pops(1, 20, got);
    n_checks++;
    if (!got || last_pop_pc !== 64'h4000) begin
      n_errors++;
      $display("FAIL same_drop_one got=%b/%h exp=1/4000", got, last_pop_pc);
    end
  endtask

  task automatic test_wrap();
    bit got;
    do_reset();
    resp_en = 1'b0;
    redirect_valid_pyri = 1'b1;
    redirect_pc_pyri = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    redirect_valid_pyri = 1'b0;
    tick();
    n_checks++;
    if (last_acc !== 64'hFFFF_FFFF_FFFF_FFFC) begin
      n_errors++;
      $display("FAIL wrap_top got=%h exp=fffffffffffffffc", last_acc);
    end
    tick();
    n_checks++;
    if (last_acc !== 64'h0 || n_acc != 2) begin
      n_errors++;
      $display("FAIL wrap_zero got=%h/%0d exp=0/2", last_acc, n_acc);
    end
    resp_en = 1'b1;
    wait_pops(2, 20, got);
    n_checks++;
    if (!got || last_pop_pc !== 64'h0) begin
      n_errors++;
      $display("FAIL wrap_out got=%b/%h exp=1/0", got, last_pop_pc);
    end
  endtask

  task automatic rand_inputs(input bit allow_redirect);
    bit prev;
    prev = redirect_valid_pyri;
    redirect_valid_pyri = allow_redirect && (prev ? ($urandom_range(2, 0) == 0) : ($urandom_range(24, 0) == 0));
    redirect_pc_pyri = ($urandom_range(7, 0) == 0) ? (64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15, 0)))
                                                  : {$urandom(), $urandom()};
    inst_retry_pyri = ($urandom_range(3, 0) == 0);
    pc_retry_pyri = ($urandom_range(5, 0) == 0);
    imem_addr_retry_pyri = ($urandom_range(3, 0) == 0);
    resp_en = ($urandom_range(3, 0) != 0);
  endtask

  task automatic test_reset_mid();
    do_reset();
    lat_max = 3;
    repeat (30) begin
      rand_inputs(1'b0);
      tick();
    end
    reset_pyri = 1'b0;
    tick();
    set_idle();
    #1;
    n_checks++;
    if (inst_valid_pyro !== 1'b0 || pc_valid_pyro !== 1'b0 || imem_addr_pyro !== RST_PC) begin
      n_errors++;
      $display("FAIL mid_reset got=%b/%b/%h exp=0/0/%h", inst_valid_pyro, pc_valid_pyro, imem_addr_pyro, RST_PC);
    end
    n_pop = 0;
    repeat (20) tick();
    n_checks++;
    if (n_pop == 0 || last_pop_pc !== RST_PC + 64'(4 * (n_pop - 1))) begin
      n_errors++;
      $display("FAIL mid_restart pops=%0d last=%h exp=%h", n_pop, last_pop_pc, RST_PC + 64'(4 * (n_pop - 1)));
    end
  endtask

  task automatic test_random();
    do_reset();
    lat_max = 3;
    repeat (2500) begin
      rand_inputs(1'b1);
      tick();
    end
    set_idle();
    repeat (10) tick();
    n_checks++;
    if (n_pop < 200) begin
      n_errors++;
      $display("FAIL random_progress pops=%0d exp>=200", n_pop);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    occ = 0;
    epoch = 0;
    cyc = 0;
    n_acc = 0;
    n_pop = 0;
    lat_max = 1;
    resp_en = 1'b1;
    exp_req_pc = RST_PC;
    exp_out_pc = RST_PC;
    last_acc = 64'h0;
    last_pop_pc = 64'h0;
    @(posedge clk);
    #1;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_same_cycle();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

endmodule
